// File: rtl/fb_pkg.sv
`default_nettype none
// ==================================================================
// fb_pkg : shared defaults and types for the frame-buffer arbiter
// Rev 1.0
// ==================================================================
package fb_pkg;

  localparam int IMG_W_DEF   = 176;
  localparam int IMG_H_DEF   = 144;
  localparam int H_TOTAL_DEF = 795;
  localparam int V_TOTAL_DEF = 525;
  localparam int ADDR_W_DEF  = 15;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam logic [7:0] BG_COLOR_DEF = 8'h00;

  // Which kind of RAM access the current cycle's slot was used for.
  typedef enum logic {
    SLOT_WRITE = 1'b0,
    SLOT_READ  = 1'b1
  } slot_e;

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ==================================================================
// fb_wr_fifo : synchronous FIFO holding {addr,data} camera writes
// Rev 1.0
// ==================================================================
module fb_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ==================================================================
// fb_arbiter : VGA read / camera write slot scheduler for one RAM port
// Optional macro FB_STALL_CNT_EN adds the WR_STALL_CNT output. Rev 1.0
// ==================================================================
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int         IMG_W      = IMG_W_DEF,
  parameter int         IMG_H      = IMG_H_DEF,
  parameter int         H_TOTAL    = H_TOTAL_DEF,
  parameter int         V_TOTAL    = V_TOTAL_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET_NEG,
  input  logic [9:0]        PIXEL_X,
  input  logic [9:0]        PIXEL_Y,
  output logic [7:0]        PIXEL_COLOR,
  input  logic              CAM_WR_VALID,
  output logic              CAM_WR_READY,
  input  logic [ADDR_W-1:0] CAM_WR_ADDR,
  input  logic [7:0]        CAM_WR_DATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [7:0]        MEM_WDATA,
`ifdef FB_STALL_CNT_EN
  output logic [15:0]       WR_STALL_CNT,
`endif
  input  logic [7:0]        MEM_RDATA
);

  logic [9:0]          nx, ny;
  logic                read_slot;
  logic [ADDR_W-1:0]   rd_addr;
  logic                fifo_full, fifo_empty, fifo_push;
  logic [ADDR_W+7:0]   fifo_head;
  logic [ADDR_W-1:0]   head_addr;
  logic [7:0]          head_data;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  slot_e               in_img_q, in_img_d;
  logic                ready_q, ready_d;

  // Address the pixel after the current one to hide the RAM read latency.
  always_comb begin
    nx = PIXEL_X + 10'd1;
    ny = PIXEL_Y;
    if (PIXEL_X == 10'(H_TOTAL - 1)) begin
      nx = '0;
      ny = (PIXEL_Y == 10'(V_TOTAL - 1)) ? '0 : PIXEL_Y + 10'd1;
    end
  end

  assign read_slot = (nx < 10'(IMG_W)) && (ny < 10'(IMG_H));
  assign rd_addr   = ADDR_W'(ny) * ADDR_W'(IMG_W) + ADDR_W'(nx);
  assign head_addr = fifo_head[ADDR_W+7:8];
  assign head_data = fifo_head[7:0];

  assign MEM_WE       = !read_slot && !fifo_empty;
  assign MEM_WDATA    = MEM_WE ? head_data : 8'h00;
  assign CAM_WR_READY = ready_q && !fifo_full;
  assign fifo_push    = CAM_WR_VALID && CAM_WR_READY;
  assign PIXEL_COLOR  = (in_img_q == SLOT_READ) ? MEM_RDATA : BG_COLOR;
  assign MEM_ADDR     = mem_addr_d;

  // An idle write slot keeps the previous address on the bus.
  always_comb begin
    mem_addr_d = mem_addr_q;
    in_img_d   = read_slot ? SLOT_READ : SLOT_WRITE;
    ready_d    = 1'b1;
    if (!RESET_NEG)      mem_addr_d = '0;
    else if (read_slot)  mem_addr_d = rd_addr;
    else if (!fifo_empty) mem_addr_d = head_addr;
  end

  always_ff @(posedge CLOCK or negedge RESET_NEG) begin
    if (!RESET_NEG) begin
      mem_addr_q <= '0;
      in_img_q   <= SLOT_WRITE;
      ready_q    <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      in_img_q   <= in_img_d;
      ready_q    <= ready_d;
    end
  end

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 8)
  ) u_wr_fifo (
    .clk   (CLOCK),
    .rst_n (RESET_NEG),
    .push  (fifo_push),
    .pop   (MEM_WE),
    .wdata ({CAM_WR_ADDR, CAM_WR_DATA}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        frame_end;

  assign frame_end    = (PIXEL_X == 10'(H_TOTAL - 1)) && (PIXEL_Y == 10'(V_TOTAL - 1));
  assign WR_STALL_CNT = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (frame_end)
      stall_cnt_d = '0;
    else if (CAM_WR_VALID && !CAM_WR_READY && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLOCK or negedge RESET_NEG) begin
    if (!RESET_NEG) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ==================================================================
// tb_fb_arbiter : directed bench with a queue-based reference model
// Rev 1.0
// ==================================================================
module tb_fb_arbiter;

  localparam int IMG_W = 176;
  localparam int IMG_H = 144;
  localparam int HT    = 795;
  localparam int VT    = 525;

  logic        CLOCK = 1'b0;
  logic        RESET_NEG = 1'b0;
  logic [9:0]  PIXEL_X = '0;
  logic [9:0]  PIXEL_Y = '0;
  logic [7:0]  PIXEL_COLOR;
  logic        CAM_WR_VALID = 1'b0;
  logic        CAM_WR_READY;
  logic [14:0] CAM_WR_ADDR = '0;
  logic [7:0]  CAM_WR_DATA = '0;
  logic [14:0] MEM_ADDR;
  logic        MEM_WE;
  logic [7:0]  MEM_WDATA;
  logic [7:0]  MEM_RDATA = '0;
`ifdef FB_STALL_CNT_EN
  logic [15:0] WR_STALL_CNT;
`endif

  fb_arbiter dut (
    .CLOCK        (CLOCK),
    .RESET_NEG    (RESET_NEG),
    .PIXEL_X      (PIXEL_X),
    .PIXEL_Y      (PIXEL_Y),
    .PIXEL_COLOR  (PIXEL_COLOR),
    .CAM_WR_VALID (CAM_WR_VALID),
    .CAM_WR_READY (CAM_WR_READY),
    .CAM_WR_ADDR  (CAM_WR_ADDR),
    .CAM_WR_DATA  (CAM_WR_DATA),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WE       (MEM_WE),
    .MEM_WDATA    (MEM_WDATA),
`ifdef FB_STALL_CNT_EN
    .WR_STALL_CNT (WR_STALL_CNT),
`endif
    .MEM_RDATA    (MEM_RDATA)
  );

  always #5 CLOCK = ~CLOCK;

  // Synchronous RAM, one-cycle read latency.
  logic [7:0] ram [0:32767];
  always @(posedge CLOCK) begin
    MEM_RDATA <= ram[MEM_ADDR];
    if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: pending writes as a plain queue.
  logic [22:0] mq [$];
  bit          ready_en  = 1'b0;
  bit          prev_rd   = 1'b0;
  logic [7:0]  prev_val  = '0;
  logic [14:0] last_addr = '0;
  int          stall     = 0;
  bit          e_rd, e_we, e_ready;
  logic [14:0] e_addr = '0;

  always @(negedge CLOCK) begin : cmp
    int nx;
    int ny;
    nx = int'(PIXEL_X) + 1;
    ny = int'(PIXEL_Y);
    if (int'(PIXEL_X) == HT - 1) begin
      nx = 0;
      ny = (int'(PIXEL_Y) == VT - 1) ? 0 : int'(PIXEL_Y) + 1;
    end
    e_rd    = RESET_NEG && (nx < IMG_W) && (ny < IMG_H);
    e_we    = RESET_NEG && !e_rd && (mq.size() > 0);
    e_ready = RESET_NEG && ready_en && (mq.size() < 8);
    if (!RESET_NEG)  e_addr = '0;
    else if (e_rd)   e_addr = 15'(ny * IMG_W + nx);
    else if (e_we)   e_addr = mq[0][22:8];
    else             e_addr = last_addr;
    chk("mem_we", 32'(MEM_WE), 32'(e_we));
    chk("mem_addr", 32'(MEM_ADDR), 32'(e_addr));
    chk("wr_ready", 32'(CAM_WR_READY), 32'(e_ready));
    chk("pixel_color", 32'(PIXEL_COLOR), (RESET_NEG && prev_rd) ? 32'(prev_val) : 32'h00);
    if (!RESET_NEG)  chk("mem_wdata_rst", 32'(MEM_WDATA), 32'h00);
    else if (e_we)   chk("mem_wdata", 32'(MEM_WDATA), 32'(mq[0][7:0]));
`ifdef FB_STALL_CNT_EN
    chk("stall_cnt", 32'(WR_STALL_CNT), 32'(stall));
`endif
  end

  always @(posedge CLOCK) begin
    if (!RESET_NEG) begin
      mq.delete();
      ready_en  = 1'b0;
      prev_rd   = 1'b0;
      last_addr = '0;
      stall     = 0;
    end else begin
      prev_rd   = e_rd;
      prev_val  = ram[e_addr];
      last_addr = e_addr;
      if (int'(PIXEL_X) == HT - 1 && int'(PIXEL_Y) == VT - 1) stall = 0;
      else if (CAM_WR_VALID && !e_ready && stall < 65535)    stall++;
      if (e_we) void'(mq.pop_front());
      if (CAM_WR_VALID && e_ready) mq.push_back({CAM_WR_ADDR, CAM_WR_DATA});
      ready_en = 1'b1;
    end
  end

  task automatic drive(input int x, input int y, input logic v,
                       input logic [14:0] a, input logic [7:0] d);
    PIXEL_X      = 10'(x);
    PIXEL_Y      = 10'(y);
    CAM_WR_VALID = v;
    CAM_WR_ADDR  = a;
    CAM_WR_DATA  = d;
    #3;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    int pushed;
    bit acc;
    bit v;
    for (int i = 0; i < 32768; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[355] = 8'h3C;

    // Power-up reset
    RESET_NEG = 1'b0;
    tick();
    drive(0, 0, 1'b0, '0, '0);
    chk("rst_we", 32'(MEM_WE), 0);
    chk("rst_ready", 32'(CAM_WR_READY), 0);
    chk("rst_addr", 32'(MEM_ADDR), 0);
    chk("rst_color", 32'(PIXEL_COLOR), 0);
    tick();
    RESET_NEG = 1'b1;
    drive(600, 10, 1'b0, '0, '0);
    chk("release_ready_low", 32'(CAM_WR_READY), 0);
    tick();
    drive(601, 10, 1'b0, '0, '0);
    chk("release_ready_high", 32'(CAM_WR_READY), 1);
    tick();

    // Blanking write
    drive(700, 10, 1'b1, 15'h0005, 8'hA5);
    tick();
    drive(701, 10, 1'b0, '0, '0);
    chk("blank_we", 32'(MEM_WE), 1);
    chk("blank_addr", 32'(MEM_ADDR), 32'h5);
    chk("blank_wdata", 32'(MEM_WDATA), 32'hA5);
    tick();
    drive(702, 10, 1'b0, '0, '0);
    chk("idle_addr_hold", 32'(MEM_ADDR), 32'h5);
    tick();

    // Read alignment
    drive(2, 2, 1'b0, '0, '0);
    chk("read_addr", 32'(MEM_ADDR), 355);
    chk("read_we", 32'(MEM_WE), 0);
    tick();
    drive(3, 2, 1'b0, '0, '0);
    chk("read_color", 32'(PIXEL_COLOR), 32'h3C);
    tick();

    // Window edges
    drive(793, 143, 1'b1, 15'h0777, 8'h77);
    tick();
    drive(794, 143, 1'b0, '0, '0);
    chk("last_line_wrap_we", 32'(MEM_WE), 1);
    chk("last_line_wrap_addr", 32'(MEM_ADDR), 32'h777);
    tick();
    drive(174, 0, 1'b1, 15'h0123, 8'h12);
    tick();
    drive(175, 0, 1'b0, '0, '0);
    chk("edge_x175_we", 32'(MEM_WE), 1);
    chk("edge_x175_addr", 32'(MEM_ADDR), 32'h123);
    chk("edge_x175_color", 32'(PIXEL_COLOR), 32'hF5);
    tick();
    drive(176, 0, 1'b0, '0, '0);
    chk("edge_x176_color", 32'(PIXEL_COLOR), 32'h00);
    tick();

    // Full FIFO inside the image
    pushed = 0;
    for (int x = 0; x <= 190; x++) begin
      v = (pushed < 9);
      drive(x, 5, v, 15'(32'h100 + pushed), 8'(32'h10 + pushed));
      if (x == 8)   chk("full_ready_low", 32'(CAM_WR_READY), 0);
      if (x == 175) begin
        chk("drain_first_we", 32'(MEM_WE), 1);
        chk("drain_first_addr", 32'(MEM_ADDR), 32'h100);
        chk("drain_first_data", 32'(MEM_WDATA), 32'h10);
      end
      if (x == 176) chk("ready_reasserts", 32'(CAM_WR_READY), 1);
      if (x == 183) chk("drain_ninth_addr", 32'(MEM_ADDR), 32'h108);
      acc = v && CAM_WR_READY;
      tick();
      if (acc) pushed++;
    end

    // Frame start reads address 0, then stall counting
    drive(794, 524, 1'b0, '0, '0);
    chk("frame_wrap_addr", 32'(MEM_ADDR), 0);
    chk("frame_wrap_we", 32'(MEM_WE), 0);
    tick();
    for (int x = 0; x < 28; x++) begin
      drive(x, 0, 1'b1, 15'(32'h200 + x), 8'(x));
      if (x == 0) chk("frame_wrap_color", 32'(PIXEL_COLOR), 32'h5A);
      tick();
    end
    drive(28, 0, 1'b0, '0, '0);
    chk("stall_full_ready", 32'(CAM_WR_READY), 0);
`ifdef FB_STALL_CNT_EN
    chk("stall_cnt_20", 32'(WR_STALL_CNT), 20);
`endif
    tick();
    for (int x = 700; x < 710; x++) begin
      drive(x, 0, 1'b0, '0, '0);
      tick();
    end
    drive(794, 524, 1'b0, '0, '0);
    tick();
    drive(0, 0, 1'b0, '0, '0);
`ifdef FB_STALL_CNT_EN
    chk("stall_cnt_cleared", 32'(WR_STALL_CNT), 0);
`endif
    tick();

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(10 + i, 3, 1'b1, 15'(32'h300 + i), 8'(32'h30 + i));
      tick();
    end
    RESET_NEG = 1'b0;
    drive(700, 3, 1'b0, '0, '0);
    chk("middrain_rst_we", 32'(MEM_WE), 0);
    chk("middrain_rst_ready", 32'(CAM_WR_READY), 0);
    chk("middrain_rst_addr", 32'(MEM_ADDR), 0);
    tick();
    drive(701, 3, 1'b0, '0, '0);
    tick();
    RESET_NEG = 1'b1;
    drive(702, 3, 1'b0, '0, '0);
    chk("middrain_release_ready", 32'(CAM_WR_READY), 0);
    chk("middrain_release_we", 32'(MEM_WE), 0);
    tick();
    drive(703, 3, 1'b0, '0, '0);
    chk("middrain_after_ready", 32'(CAM_WR_READY), 1);
    chk("middrain_after_we", 32'(MEM_WE), 0);
    tick();
    for (int x = 704; x <= 710; x++) begin
      drive(x, 3, 1'b0, '0, '0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Single-port frame-buffer scheduler between the camera write path and the 640x480 VGA scan-out.
- VGA reads have absolute priority for every pixel inside the IMG_W x IMG_H window at the top-left of the screen.
- Camera writes are buffered in a small FIFO and drained in any cycle with no pending read.
- Sits between the pixel-counter VGA driver (whose X/Y it consumes and whose colour input it drives) and the synchronous frame-buffer RAM.

Parameters:
- IMG_W, 176, image width in pixels
- IMG_H, 144, image height in lines
- H_TOTAL, 795, pixel-counter wrap value (counter runs 0..H_TOTAL-1)
- V_TOTAL, 525, line-counter wrap value (counter runs 0..V_TOTAL-1)
- ADDR_W, 15, frame-buffer address width
- FIFO_DEPTH, 8, write FIFO entries (power of two)
- BG_COLOR, 8'h00, colour outside the image window

Ports:
- CLOCK  in  1  pixel clock, 25 MHz
- RESET_NEG  in  1  reset
- PIXEL_X  in  10  current VGA pixel counter
- PIXEL_Y  in  10  current VGA line counter
- PIXEL_COLOR  out  8  colour for the current PIXEL_X/PIXEL_Y, to the VGA driver
- CAM_WR_VALID  in  1  camera write request
- CAM_WR_READY  out  1  FIFO can accept
- CAM_WR_ADDR  in  ADDR_W  write address
- CAM_WR_DATA  in  8  write pixel
- MEM_ADDR  out  ADDR_W  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  8  RAM write data
- MEM_RDATA  in  8  RAM read data; valid one cycle after address
- WR_STALL_CNT  out  16  present only with FB_STALL_CNT_EN

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (RESET_NEG low, any time, including mid-frame or mid-drain):
  - PIXEL_COLOR=BG_COLOR, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CAM_WR_READY=0.
  - FIFO emptied; pending entries are discarded.
  - CAM_WR_READY rises the first cycle after release.
- Look-ahead: the RAM has 1-cycle read latency, so each cycle the block addresses the next pixel (NX,NY).
  - NX=PIXEL_X+1 and NY=PIXEL_Y, except when PIXEL_X==H_TOTAL-1.
  - At PIXEL_X==H_TOTAL-1: NX=0 and NY=PIXEL_Y+1, or NY=0 when PIXEL_Y==V_TOTAL-1.
- Slot decision (combinational, one per cycle):
  - READ slot when NX<IMG_W && NY<IMG_H: MEM_ADDR=NY*IMG_W+NX truncated to ADDR_W, MEM_WE=0.
  - Otherwise WRITE slot: if the FIFO is not empty, MEM_ADDR/MEM_WDATA = FIFO head, MEM_WE=1, head popped at clock edge; if the FIFO is empty, MEM_WE=0 and MEM_ADDR holds its last value.
- Colour pipeline:
  - A registered in_img flag records the slot type.
  - PIXEL_COLOR = in_img ? MEM_RDATA : BG_COLOR.
  - Read latency therefore exactly aligns with PIXEL_X.
- Write FIFO:
  - CAM_WR_READY = !full.
  - Push on CAM_WR_VALID && CAM_WR_READY.
  - No bypass: an entry pushed at edge N can reach MEM_WE=1 at the earliest in cycle N+1.
  - Push and pop on the same edge is allowed; count is unchanged.
  - A push while full cannot occur because READY is low.
  - Entries drain in order.
- Starvation bound: each image line yields H_TOTAL-IMG_W write slots, so a full FIFO drains within one line.
- No RAM write is ever issued in a READ slot.

Optional Feature:
FB_STALL_CNT_EN.
- Defined:
  - WR_STALL_CNT is a 16-bit counter, incremented each cycle with CAM_WR_VALID && !CAM_WR_READY, saturating at 16'hFFFF.
  - Cleared when PIXEL_X==H_TOTAL-1 && PIXEL_Y==V_TOTAL-1 (frame start); clearing wins over incrementing.
  - Reset value 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package fb_pkg holds the IMG_W/IMG_H/H_TOTAL/V_TOTAL defaults, the ADDR_W default and the BG_COLOR default.
- One sub-module, fb_wr_fifo: synchronous FIFO with {addr,data} entries, push/pop/full/empty, async active-low reset.
- Arbitration and look-ahead logic stay in fb_arbiter.

Test Plan:
1. Reset mid-drain: 3 entries queued, X=700; pull RESET_NEG low -> same cycle MEM_WE=0 and CAM_WR_READY=0; after release the FIFO is empty and no write occurs.
2. Blanking write: X=700,Y=10, push addr 0x0005 data 0xA5 -> next cycle MEM_WE=1, MEM_ADDR=0x0005, MEM_WDATA=0xA5.
3. Read alignment: RAM[355]=0x3C; at X=2,Y=2 -> MEM_ADDR=355, MEM_WE=0; next cycle X=3 -> PIXEL_COLOR=0x3C.
4. Window edges:
   - X=175,Y=0 -> write slot; PIXEL_COLOR=BG_COLOR at X=176.
   - X=794,Y=143 -> look-ahead (0,144), write slot.
   - X=794,Y=524 -> read of addr 0.
5. Full FIFO in image region:
   - Push 9 writes from X=0,Y=5 -> READY low after the 8th accept; no MEM_WE while NX<176.
   - From X=175 the FIFO drains one entry per cycle in order; READY re-asserts the cycle after the first pop.
6. FB_STALL_CNT_EN: hold VALID with FIFO full for 20 cycles -> WR_STALL_CNT=20; at X=794,Y=524 the counter clears to 0.
